// File: rtl/core_mem_port.sv
// rtl/core_mem_port.sv - core-side requester port onto a shared, granted memory controller
module core_mem_port #(
    parameter int READ_LAT = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start_rd,
    input  logic        start_wr,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        busy,
    output logic        req_err,
    output logic        rden,
    output logic        wren,
    output logic [7:0]  Address,
    output logic [7:0]  Din,
    input  logic [7:0]  Dq,
    input  logic        acq,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] lat_cnt;
    logic       stalled;

    // Requesting (either direction) while the controller has not granted us.
    assign stalled = ((state == RD_REQ) || (state == WR_REQ)) && !acq;

    // Controller-facing strobes and busy decode straight from the state.
    assign busy = (state != IDLE);
    assign rden = (state == RD_REQ) || (state == RD_WAIT);
    assign wren = (state == WR_REQ);

    // Next-state: a lost grant during the read window restarts the request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_rd)      state_nxt = RD_REQ;
                else if (start_wr) state_nxt = WR_REQ;
            end
            RD_REQ: begin
                if (acq) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (!acq)              state_nxt = RD_REQ;
                else if (lat_cnt == 3'd1) state_nxt = IDLE;
            end
            WR_REQ: begin
                if (acq) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request latching, read-latency countdown, capture and completion pulses.
    always_ff @(posedge CLK) begin
        if (rst) begin
            Address <= 8'h00;
            Din     <= 8'h00;
            rdata   <= 8'h00;
            lat_cnt <= 3'd0;
            done    <= 1'b0;
            req_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            req_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rd) begin
                        Address <= addr;
                        req_err <= start_wr;
                    end else if (start_wr) begin
                        Address <= addr;
                        Din     <= wdata;
                    end
                end
                RD_REQ: begin
                    if (acq) lat_cnt <= LAT_LOAD;
                end
                RD_WAIT: begin
                    if (!acq) begin
                        lat_cnt <= 3'd0;
                    end else if (lat_cnt == 3'd1) begin
                        lat_cnt <= 3'd0;
                        rdata   <= Dq;
                        done    <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                WR_REQ: begin
                    if (acq) done <= 1'b1;
                end
                default: lat_cnt <= 3'd0;
            endcase
        end
    end

    // Saturating count of ungranted request cycles; only reset clears it.
    always_ff @(posedge CLK) begin
        if (rst)                                   stall_count <= 16'h0000;
        else if (stalled && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_core_mem_port.sv
// tb/tb_core_mem_port.sv - randomized and directed checks of core_mem_port against a transaction model
module tb_core_mem_port;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        start_rd = 1'b0;
    logic        start_wr = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        done;
    logic        busy;
    logic        req_err;
    logic        rden;
    logic        wren;
    logic [7:0]  Address;
    logic [7:0]  Din;
    logic [7:0]  Dq = 8'h00;
    logic        acq = 1'b0;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    int         exp_stall = 0;
    logic [7:0] exp_rdata = 8'h00;
    logic [7:0] exp_din   = 8'h00;
    int         acq_pat[$];
    int         last_edges;
    int         last_wren_cycles;

    core_mem_port #(.READ_LAT(LAT)) dut (
        .CLK(CLK), .rst(rst), .start_rd(start_rd), .start_wr(start_wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .req_err(req_err), .rden(rden), .wren(wren), .Address(Address),
        .Din(Din), .Dq(Dq), .acq(acq), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic void bump_stall();
        if (exp_stall < 65535) exp_stall++;
    endfunction

    function automatic logic next_acq(input int pct);
        if (acq_pat.size() > 0) return acq_pat.pop_front() != 0;
        return $urandom_range(99) < pct;
    endfunction

    // A read finishes once the grant has been held for READ_LAT+1 consecutive
    // edges; a drop after the grant edge restarts the wait without counting a
    // stall, while every ungranted edge before a grant counts one stall.
    task automatic do_read(input logic [7:0] a, input int pct, input int dq_force, input logic with_wr);
        int  run;
        bit  fin;
        logic [7:0] dq_now;
        start_rd = 1'b1;
        start_wr = with_wr;
        addr  = a;
        wdata = 8'($urandom);
        step();
        start_rd = 1'b0;
        start_wr = 1'b0;
        check("rd_req_err", req_err, with_wr);
        check("rd_addr", Address, a);
        run = 0;
        fin = 0;
        for (int n = 1; n <= 300 && !fin; n++) begin
            check("rd_rden", rden, 1);
            check("rd_wren", wren, 0);
            check("rd_busy", busy, 1);
            acq = (n > 200) ? 1'b1 : next_acq(pct);
            dq_now = (dq_force >= 0) ? 8'(dq_force) : 8'($urandom);
            Dq = dq_now;
            start_rd = 1'($urandom_range(1));
            start_wr = 1'($urandom_range(1));
            step();
            start_rd = 1'b0;
            start_wr = 1'b0;
            if (run == 0) begin
                if (acq) run = 1;
                else bump_stall();
            end else if (acq) begin
                run++;
            end else begin
                run = 0;
            end
            if (run == LAT + 1) begin
                fin = 1;
                exp_rdata = dq_now;
                last_edges = n;
                check("rd_done", done, 1);
                check("rd_busy_end", busy, 0);
            end else begin
                check("rd_done_early", done, 0);
            end
            check("rd_rdata", rdata, exp_rdata);
            check("rd_req_err_busy", req_err, 0);
            check("rd_stall", stall_count, exp_stall);
        end
        if (!fin) check("rd_timeout", 0, 1);
        acq = 1'b0;
        step();
        check("rd_done_pulse", done, 0);
        check("rd_idle_rden", rden, 0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int pct);
        bit fin;
        start_wr = 1'b1;
        addr  = a;
        wdata = d;
        step();
        start_wr = 1'b0;
        exp_din = d;
        check("wr_addr", Address, a);
        check("wr_req_err", req_err, 0);
        fin = 0;
        last_wren_cycles = 0;
        for (int n = 1; n <= 300 && !fin; n++) begin
            check("wr_wren", wren, 1);
            check("wr_rden", rden, 0);
            check("wr_din", Din, exp_din);
            if (wren) last_wren_cycles++;
            acq = (n > 200) ? 1'b1 : next_acq(pct);
            Dq = 8'($urandom);
            start_rd = 1'($urandom_range(1));
            start_wr = 1'($urandom_range(1));
            step();
            start_rd = 1'b0;
            start_wr = 1'b0;
            if (acq) begin
                fin = 1;
                last_edges = n;
                check("wr_done", done, 1);
                check("wr_idle", busy, 0);
            end else begin
                bump_stall();
                check("wr_done_early", done, 0);
            end
            check("wr_stall", stall_count, exp_stall);
            check("wr_rdata_hold", rdata, exp_rdata);
        end
        if (!fin) check("wr_timeout", 0, 1);
        acq = 1'b0;
        step();
        check("wr_done_pulse", done, 0);
        check("wr_idle_wren", wren, 0);
    endtask

    initial begin
        // Reset values
        step();
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rden", rden, 0);
        check("rst_wren", wren, 0);
        check("rst_req_err", req_err, 0);
        check("rst_addr", Address, 0);
        check("rst_din", Din, 0);
        check("rst_rdata", rdata, 0);
        check("rst_stall", stall_count, 0);
        rst = 1'b0;
        step();

        // Plain read, grant always present
        do_read(8'h10, 100, 8'h5A, 1'b0);
        check("rd_latency", last_edges, 3);
        check("rd_5a", rdata, 8'h5A);
        check("rd_stall0", stall_count, 0);

        // Write held off four cycles
        acq_pat = '{0, 0, 0, 0, 1};
        do_write(8'h20, 8'hC3, 100);
        check("wr_wren_cycles", last_wren_cycles, 5);
        check("wr_c3", Din, 8'hC3);
        check("wr_stall4", stall_count, 4);

        // Grant lost during the read window, regranted later
        acq_pat = '{1, 0, 0, 0, 1, 1, 1};
        do_read(8'h33, 100, -1, 1'b0);
        check("rd_restart_edges", last_edges, 7);
        check("rd_restart_stall", stall_count, 6);

        // Simultaneous starts: read wins
        do_read(8'h44, 100, -1, 1'b1);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(1)) do_read(8'($urandom), 40 + $urandom_range(60), -1, 1'($urandom_range(3) == 0));
            else                   do_write(8'($urandom), 8'($urandom), 30 + $urandom_range(70));
        end

        // Reset in the middle of a read window
        start_rd = 1'b1;
        addr = 8'h5C;
        step();
        start_rd = 1'b0;
        acq = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        acq = 1'b0;
        exp_stall = 0;
        exp_rdata = 8'h00;
        check("mid_rst_done", done, 0);
        check("mid_rst_rden", rden, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", Address, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_stall", stall_count, 0);
        step();
        check("mid_rst_nodone", done, 0);

        // Stall counter saturation
        start_rd = 1'b1;
        addr = 8'h01;
        step();
        start_rd = 1'b0;
        acq = 1'b0;
        for (int i = 0; i < 70000; i++) @(posedge CLK);
        #1;
        check("stall_sat", stall_count, 16'hFFFF);
        check("stall_sat_rden", rden, 1);
        step();
        step();
        check("stall_sat_hold", stall_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
